// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-counter checker.
// Holds the tracking FSM states, the expected-successor rotate and the error-count ceiling.
package ring_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StLocking,
    StLocked
  } ring_state_e;

  localparam int unsigned ERR_CNT_MAX = 255;

  // Rotate the low n bits of p left by one; p must be zero above bit n-1.
  function automatic logic [63:0] rot_left(input logic [63:0] p, input int unsigned n);
    logic [63:0] mask;
    mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    return ((p << 1) | (p >> (n - 1))) & mask;
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary encoder with legality flag (valid only when exactly one bit is set).
module onehot_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         in_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = $clog2(N + 1);

  logic [CntW-1:0] cnt;

  always_comb begin
    cnt   = '0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (in_i[i]) begin
        cnt   = cnt + CntW'(1);
        idx_o = idx_o | IdxW'(i);
      end
    end
    valid_o = (cnt == CntW'(1));
  end

endmodule

// File: rtl/ring_checker.sv
// Ring-counter sequence checker: tracks rotate-left progress of a one-hot word,
// declares lock after LOCK_CNT consecutive correct steps and counts sequence errors.
module ring_checker
  import ring_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         q_in,
  input  logic                 en,
  input  logic                 err_clr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 onehot_ok,
  output logic                 locked,
  output logic                 err,
  output logic [7:0]           err_count
);

  localparam int unsigned IdxW = $clog2(N);

  ring_state_e     state_q, state_d;
  logic [3:0]      gcnt_q, gcnt_d;
  logic [N-1:0]    prev_q, prev_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            ok_q, ok_d;
  logic            locked_q, locked_d;
  logic            err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [IdxW-1:0] enc_idx;
  logic            enc_valid;
  logic [63:0]     rot_full;
  logic [N-1:0]    expect_w;
  logic            is_step;
  logic [3:0]      gcnt_inc;

  onehot_enc #(
    .N(N)
  ) u_enc (
    .in_i   (q_in),
    .idx_o  (enc_idx),
    .valid_o(enc_valid)
  );

  // prev resets to zero, so the first sample after reset can never match a rotation.
  assign rot_full = rot_left(64'(prev_q), N);
  assign expect_w = rot_full[N-1:0];
  assign is_step  = enc_valid && (q_in == expect_w);
  assign gcnt_inc = gcnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    prev_d  = prev_q;
    idx_d   = idx_q;
    ok_d    = ok_q;
    err_d   = 1'b0;
    if (en) begin
      ok_d = enc_valid;
      if (enc_valid) begin
        prev_d = q_in;
        idx_d  = enc_idx;
      end
      case (state_q)
        StHunt: begin
          if (enc_valid) begin
            state_d = StLocking;
            gcnt_d  = '0;
          end
        end
        StLocking: begin
          if (!enc_valid) begin
            state_d = StHunt;
            gcnt_d  = '0;
          end else if (is_step) begin
            if (gcnt_inc == 4'(LOCK_CNT)) begin
              state_d = StLocked;
              gcnt_d  = '0;
            end else begin
              gcnt_d = gcnt_inc;
            end
          end else begin
            gcnt_d = '0;
          end
        end
        StLocked: begin
          if (!is_step) begin
            err_d   = 1'b1;
            state_d = enc_valid ? StLocking : StHunt;
            gcnt_d  = '0;
          end
        end
        default: begin
          state_d = StHunt;
          gcnt_d  = '0;
        end
      endcase
    end
    locked_d = (state_d == StLocked);
  end

  // Clear has priority over a coincident error pulse and acts regardless of en.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = '0;
    end else if (err_d && (cnt_q != 8'(ERR_CNT_MAX))) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StHunt;
      gcnt_q   <= '0;
      prev_q   <= '0;
      idx_q    <= '0;
      ok_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gcnt_q   <= gcnt_d;
      prev_q   <= prev_d;
      idx_q    <= idx_d;
      ok_q     <= ok_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign idx       = idx_q;
  assign onehot_ok = ok_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_ring_checker.sv
// Scoreboard bench for ring_checker (N=4, LOCK_CNT=2) driven by hand-computed directed vectors.
module tb_ring_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] q_in = '0;
  logic       en = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] idx;
  logic       onehot_ok;
  logic       locked;
  logic       err;
  logic [7:0] err_count;

  typedef struct {
    logic [1:0] idx;
    logic       ok;
    logic       lock;
    logic       err;
    logic [7:0] cnt;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   tag_n = 0;

  ring_checker #(
    .N(4),
    .LOCK_CNT(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .q_in     (q_in),
    .en       (en),
    .err_clr  (err_clr),
    .idx      (idx),
    .onehot_ok(onehot_ok),
    .locked   (locked),
    .err      (err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int tag, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (vec %0d): got %0d want %0d", name, tag, act, exp);
    end
  endtask

  // Drive one sample at the falling edge and queue the outputs expected after the next rise.
  task automatic cyc(input logic [3:0] q, input logic e, input logic clr, input logic [1:0] x_idx,
                     input logic x_ok, input logic x_lock, input logic x_err,
                     input logic [7:0] x_cnt);
    exp_t x;
    @(negedge clk);
    q_in    = q;
    en      = e;
    err_clr = clr;
    tag_n++;
    x.idx  = x_idx;
    x.ok   = x_ok;
    x.lock = x_lock;
    x.err  = x_err;
    x.cnt  = x_cnt;
    x.tag  = tag_n;
    sb.push_back(x);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk("idx", x.tag, 8'(idx), 8'(x.idx));
      chk("onehot_ok", x.tag, 8'(onehot_ok), 8'(x.ok));
      chk("locked", x.tag, 8'(locked), 8'(x.lock));
      chk("err", x.tag, 8'(err), 8'(x.err));
      chk("err_count", x.tag, err_count, x.cnt);
    end
  end

  initial begin
    logic [7:0] c;
    #2;
    chk("rst_idx", 0, 8'(idx), 8'd0);
    chk("rst_ok", 0, 8'(onehot_ok), 8'd0);
    chk("rst_locked", 0, 8'(locked), 8'd0);
    chk("rst_err", 0, 8'(err), 8'd0);
    chk("rst_cnt", 0, err_count, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // Acquire lock, then wrap.
    cyc(4'b0001, 1, 0, 2'd0, 1, 0, 0, 8'd0);
    cyc(4'b0010, 1, 0, 2'd1, 1, 0, 0, 8'd0);
    cyc(4'b0100, 1, 0, 2'd2, 1, 1, 0, 8'd0);
    cyc(4'b1000, 1, 0, 2'd3, 1, 1, 0, 8'd0);
    cyc(4'b0001, 1, 0, 2'd0, 1, 1, 0, 8'd0);
    cyc(4'b0010, 1, 0, 2'd1, 1, 1, 0, 8'd0);
    // SLIP while locked, then relock.
    cyc(4'b1000, 1, 0, 2'd3, 1, 0, 1, 8'd1);
    cyc(4'b0001, 1, 0, 2'd0, 1, 0, 0, 8'd1);
    cyc(4'b0010, 1, 0, 2'd1, 1, 1, 0, 8'd1);
    // ILLEGAL while locked holds idx; 0000 in HUNT gives no err.
    cyc(4'b0110, 1, 0, 2'd1, 0, 0, 1, 8'd2);
    cyc(4'b0000, 1, 0, 2'd1, 0, 0, 0, 8'd2);
    cyc(4'b0100, 1, 0, 2'd2, 1, 0, 0, 8'd2);
    cyc(4'b1000, 1, 0, 2'd3, 1, 0, 0, 8'd2);
    cyc(4'b0001, 1, 0, 2'd0, 1, 1, 0, 8'd2);
    cyc(4'b0000, 1, 0, 2'd0, 0, 0, 1, 8'd3);
    // Repeated word is a SLIP, both in LOCKING and in LOCKED.
    cyc(4'b0010, 1, 0, 2'd1, 1, 0, 0, 8'd3);
    cyc(4'b0010, 1, 0, 2'd1, 1, 0, 0, 8'd3);
    cyc(4'b0100, 1, 0, 2'd2, 1, 0, 0, 8'd3);
    cyc(4'b1000, 1, 0, 2'd3, 1, 1, 0, 8'd3);
    cyc(4'b1000, 1, 0, 2'd3, 1, 0, 1, 8'd4);
    // err_clr acts with en=0; everything else holds.
    cyc(4'b0110, 0, 1, 2'd3, 1, 0, 0, 8'd0);
    cyc(4'b0000, 1, 0, 2'd3, 0, 0, 0, 8'd0);
    // 260 errors: count saturates at 255.
    c = 8'd0;
    for (int k = 0; k < 260; k++) begin
      cyc(4'b0001, 1, 0, 2'd0, 1, 0, 0, c);
      cyc(4'b0010, 1, 0, 2'd1, 1, 0, 0, c);
      cyc(4'b0100, 1, 0, 2'd2, 1, 1, 0, c);
      if (c != 8'd255) c = c + 8'd1;
      cyc(4'b0000, 1, 0, 2'd2, 0, 0, 1, c);
    end
    // Clear coincident with an err pulse: clear wins, err still pulses.
    cyc(4'b1000, 1, 0, 2'd3, 1, 0, 0, 8'd255);
    cyc(4'b0001, 1, 0, 2'd0, 1, 0, 0, 8'd255);
    cyc(4'b0010, 1, 0, 2'd1, 1, 1, 0, 8'd255);
    cyc(4'b1000, 1, 1, 2'd3, 1, 0, 1, 8'd0);
    // en=0 gaps mid-sequence hold everything, including a would-be SLIP.
    cyc(4'b0001, 1, 0, 2'd0, 1, 0, 0, 8'd0);
    cyc(4'b0110, 0, 0, 2'd0, 1, 0, 0, 8'd0);
    cyc(4'b0010, 1, 0, 2'd1, 1, 1, 0, 8'd0);
    cyc(4'b1000, 0, 0, 2'd1, 1, 1, 0, 8'd0);
    cyc(4'b0100, 1, 0, 2'd2, 1, 1, 0, 8'd0);
    // Nonzero count, relock, then asynchronous reset between edges.
    cyc(4'b0001, 1, 0, 2'd0, 1, 0, 1, 8'd1);
    cyc(4'b0010, 1, 0, 2'd1, 1, 0, 0, 8'd1);
    cyc(4'b0100, 1, 0, 2'd2, 1, 1, 0, 8'd1);
    @(posedge clk);
    #3;
    en    = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_locked", tag_n, 8'(locked), 8'd0);
    chk("async_cnt", tag_n, err_count, 8'd0);
    chk("async_idx", tag_n, 8'(idx), 8'd0);
    chk("async_ok", tag_n, 8'(onehot_ok), 8'd0);
    @(negedge clk);
    reset = 1'b1;
    // Fresh HUNT/LOCKING sequence required after reset.
    cyc(4'b1000, 1, 0, 2'd3, 1, 0, 0, 8'd0);
    cyc(4'b0001, 1, 0, 2'd0, 1, 0, 0, 8'd0);
    cyc(4'b0010, 1, 0, 2'd1, 1, 1, 0, 8'd0);
    cyc(4'b0100, 0, 0, 2'd1, 1, 1, 0, 8'd0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
